dmem_arbiter: RTL and testbench

Shares the single synchronous data-memory port among the processor cores of the multi-core build. Each core's data-side interface (Mem_Ctrl, DAddress, Ddout, Ddin, dacq) connects to one slot. The block grants one core at a time in round-robin order, sequences the RAM read or write, returns read data, and pulses that core's dacq. It sits between the core array and the data RAM at top level.

---
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous data-RAM port among NCORES core slots.
// Each grant runs a single write (IDLE-WR-ACK) or read (IDLE-RD-RDW-ACK) transfer.
module dmem_arbiter #(
  parameter int unsigned NCORES = 4,
  parameter int unsigned IDW    = 2
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [4*NCORES-1:0] core_memctrl,
  input  logic [8*NCORES-1:0] core_daddr,
  input  logic [8*NCORES-1:0] core_ddout,
  output logic [8*NCORES-1:0] core_ddin,
  output logic [NCORES-1:0]   core_dacq,
  output logic [7:0]          mem_addr,
  output logic [7:0]          mem_din,
  output logic                mem_we,
  input  logic [7:0]          mem_dout,
  output logic                busy,
  output logic [IDW-1:0]      grant_id
);

  localparam int unsigned CW = 4;
  localparam int unsigned DW = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    RDW  = 3'd3,
    ACK  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [IDW-1:0]        rr_ptr, rr_d;
  logic [IDW-1:0]        grant_d;
  logic                  mask_vld, mask_d;
  logic [DW-1:0]         addr_d, din_d;
  logic                  we_d;
  logic [NCORES-1:0]     dacq_d;
  logic [DW*NCORES-1:0]  ddin_d;
  logic                  busy_d;

  logic [NCORES-1:0]     req, elig, grant_oh;
  logic                  found, sel_wr;
  logic [IDW-1:0]        sel;
  logic [DW-1:0]         sel_addr, sel_data;
  logic                  unused_ctrl;

  // Request decode; the core served last is masked for one IDLE cycle after its ACK
  always_comb begin
    req         = '0;
    elig        = '0;
    grant_oh    = '0;
    unused_ctrl = 1'b0;
    for (int k = 0; k < int'(NCORES); k++) begin
      req[k]      = core_memctrl[CW*k] | core_memctrl[CW*k+1];
      elig[k]     = req[k] & ~(mask_vld & (grant_id == IDW'(k)));
      grant_oh[k] = (grant_id == IDW'(k));
      unused_ctrl = unused_ctrl ^ core_memctrl[CW*k+2] ^ core_memctrl[CW*k+3];
    end
  end

  // First eligible requester searching upward from rr_ptr, wrapping at NCORES
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    sel_wr   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NCORES); i++) begin
      int pos;
      pos = int'(32'(rr_ptr)) + i;
      if (pos >= int'(NCORES)) pos = pos - int'(NCORES);
      for (int k = 0; k < int'(NCORES); k++) begin
        if (!found && elig[k] && (k == pos)) begin
          found    = 1'b1;
          sel      = IDW'(k);
          sel_wr   = core_memctrl[CW*k+1];
          sel_addr = core_daddr[DW*k +: DW];
          sel_data = core_ddout[DW*k +: DW];
        end
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    rr_d    = rr_ptr;
    grant_d = grant_id;
    addr_d  = mem_addr;
    din_d   = mem_din;
    we_d    = 1'b0;
    dacq_d  = '0;
    ddin_d  = core_ddin;
    mask_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = sel;
          addr_d  = sel_addr;
          rr_d    = (sel == IDW'(NCORES - 1)) ? '0 : sel + 1'b1;
          if (sel_wr) begin
            din_d   = sel_data;
            we_d    = 1'b1;
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      WR: begin
        dacq_d  = grant_oh;
        state_d = ACK;
      end
      RD: state_d = RDW;
      RDW: begin
        for (int k = 0; k < int'(NCORES); k++) begin
          if (grant_oh[k]) ddin_d[DW*k +: DW] = mem_dout;
        end
        dacq_d  = grant_oh;
        state_d = ACK;
      end
      ACK: begin
        mask_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      mask_vld  <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_we    <= 1'b0;
      core_dacq <= '0;
      core_ddin <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr    <= rr_d;
      grant_id  <= grant_d;
      mask_vld  <= mask_d;
      mem_addr  <= addr_d;
      mem_din   <= din_d;
      mem_we    <= we_d;
      core_dacq <= dacq_d;
      core_ddin <= ddin_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous RAM.
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [15:0] core_memctrl;
  logic [31:0] core_daddr;
  logic [31:0] core_ddout;
  logic [31:0] core_ddin;
  logic [3:0]  core_dacq;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [7:0]  mem_dout;
  logic        busy;
  logic [1:0]  grant_id;

  logic [7:0]  ram [0:255];
  logic        pl_we;
  logic [7:0]  pl_addr, pl_data;
  int          ncmp = 0;
  int          nerr = 0;
  int          we_cnt = 0;
  int          we_base;

  always #5 CLK = ~CLK;

  dmem_arbiter #(.NCORES(4), .IDW(2)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .core_memctrl(core_memctrl), .core_daddr(core_daddr), .core_ddout(core_ddout),
    .core_ddin(core_ddin), .core_dacq(core_dacq),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
    .busy(busy), .grant_id(grant_id)
  );

  // Synchronous RAM: read data valid one cycle after the address; preload port for setup
  always @(posedge CLK) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    else if (pl_we) ram[pl_addr] <= pl_data;
    mem_dout <= ram[mem_addr];
  end

  always @(posedge CLK) if (mem_we) we_cnt++;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_core(input int k, input logic [3:0] ctrl, input logic [7:0] a,
                          input logic [7:0] d);
    core_memctrl[4*k +: 4] = ctrl;
    core_daddr[8*k +: 8]   = a;
    core_ddout[8*k +: 8]   = d;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    tick;
    pl_we = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_we"},    32'(mem_we),    32'h0);
    check({tag, "_busy"},  32'(busy),      32'h0);
    check({tag, "_dacq"},  32'(core_dacq), 32'h0);
    check({tag, "_grant"}, 32'(grant_id),  32'h0);
    check({tag, "_addr"},  32'(mem_addr),  32'h0);
    check({tag, "_din"},   32'(mem_din),   32'h0);
    check({tag, "_ddin"},  core_ddin,      32'h0);
  endtask

  initial begin
    RSTn = 1'b0; core_memctrl = '0; core_daddr = '0; core_ddout = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    #2;
    check_reset("rst0");
    preload(8'h20, 8'hA5);
    for (int k = 0; k < 4; k++) preload(8'(8'h10 + k), 8'(8'h50 + k));
    preload(8'h70, 8'hEE);
    tick;
    RSTn = 1'b1;
    tick;
    check("idle_no_req", 32'(busy), 32'h0);

    // Single read: core1 reads 0x20
    set_core(1, 4'b0001, 8'h20, 8'h00);
    tick;
    check("rd1_busy",  32'(busy),      32'h1);
    check("rd1_grant", 32'(grant_id),  32'h1);
    check("rd1_addr",  32'(mem_addr),  32'h20);
    check("rd1_we",    32'(mem_we),    32'h0);
    tick;
    check("rd1_dacq_early", 32'(core_dacq), 32'h0);
    tick;
    check("rd1_dacq", 32'(core_dacq),        32'h2);
    check("rd1_data", 32'(core_ddin[15:8]),  32'hA5);
    set_core(1, 4'b0000, 8'h00, 8'h00);
    tick;
    check("rd1_dacq_end", 32'(core_dacq), 32'h0);
    check("rd1_idle",     32'(busy),      32'h0);

    // Write: core2 writes 0x3C to 0x40
    set_core(2, 4'b0010, 8'h40, 8'h3C);
    tick;
    check("wr2_we",    32'(mem_we),   32'h1);
    check("wr2_addr",  32'(mem_addr), 32'h40);
    check("wr2_din",   32'(mem_din),  32'h3C);
    check("wr2_grant", 32'(grant_id), 32'h2);
    tick;
    check("wr2_we_off", 32'(mem_we),    32'h0);
    check("wr2_dacq",   32'(core_dacq), 32'h4);
    set_core(2, 4'b0000, 8'h00, 8'h00);
    tick;
    check("wr2_dacq_end", 32'(core_dacq), 32'h0);
    check("wr2_ram",      32'(ram[8'h40]), 32'h3C);

    // Core0 reads back 0x40
    set_core(0, 4'b0001, 8'h40, 8'h00);
    tick;
    check("rd0_grant", 32'(grant_id), 32'h0);
    tick;
    tick;
    check("rd0_dacq", 32'(core_dacq),      32'h1);
    check("rd0_data", 32'(core_ddin[7:0]), 32'h3C);
    set_core(0, 4'b0000, 8'h00, 8'h00);
    tick;
    check("rd0_idle", 32'(busy), 32'h0);

    // Contention from reset: all four cores read
    RSTn = 1'b0;
    #1;
    check("rst1_ddin",  core_ddin,      32'h0);
    check("rst1_grant", 32'(grant_id),  32'h0);
    tick;
    for (int k = 0; k < 4; k++) set_core(k, 4'b0001, 8'(8'h10 + k), 8'h00);
    RSTn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      check("rr_grant", 32'(grant_id), 32'(k));
      check("rr_busy",  32'(busy),     32'h1);
      tick;
      tick;
      check("rr_dacq", 32'(core_dacq),          32'(1 << k));
      check("rr_data", 32'(core_ddin[8*k +: 8]), 32'(8'h50 + k));
      if (k < 3) set_core(k, 4'b0000, 8'h00, 8'h00);
      tick;
      check("rr_ack_idle", 32'(busy), 32'h0);
    end
    tick;
    check("rr_core3_masked", 32'(busy), 32'h0);
    tick;
    check("rr_core3_regrant", 32'(busy),     32'h1);
    check("rr_core3_gid",     32'(grant_id), 32'h3);
    tick;
    tick;
    check("rr_core3_dacq", 32'(core_dacq), 32'h8);
    set_core(3, 4'b0000, 8'h00, 8'h00);
    tick;

    // Held write request: exactly one mem_we pulse
    we_base = we_cnt;
    set_core(0, 4'b0010, 8'h50, 8'h77);
    tick;
    check("held_we",    32'(mem_we),   32'h1);
    check("held_grant", 32'(grant_id), 32'h0);
    tick;
    check("held_dacq", 32'(core_dacq), 32'h1);
    tick;
    check("held_ack_idle", 32'(busy), 32'h0);
    tick;
    check("held_masked", 32'(busy), 32'h0);
    set_core(0, 4'b0000, 8'h00, 8'h00);
    tick;
    check("held_idle",   32'(busy),            32'h0);
    check("held_pulses", 32'(we_cnt - we_base), 32'h1);
    check("held_ram",    32'(ram[8'h50]),      32'h77);

    // Both request bits: treated as write
    we_base = we_cnt;
    set_core(3, 4'b0011, 8'h60, 8'h99);
    tick;
    check("both_we",    32'(mem_we),   32'h1);
    check("both_grant", 32'(grant_id), 32'h3);
    check("both_din",   32'(mem_din),  32'h99);
    tick;
    check("both_dacq", 32'(core_dacq), 32'h8);
    set_core(3, 4'b0000, 8'h00, 8'h00);
    tick;
    check("both_ddin",   32'(core_ddin[31:24]), 32'h53);
    check("both_ram",    32'(ram[8'h60]),       32'h99);
    check("both_pulses", 32'(we_cnt - we_base), 32'h1);

    // Reset in the middle of a write
    set_core(2, 4'b0010, 8'h70, 8'h11);
    tick;
    check("rstw_we_pre", 32'(mem_we), 32'h1);
    #2;
    RSTn = 1'b0;
    #1;
    check_reset("rstw");
    tick;
    check("rstw_ram", 32'(ram[8'h70]), 32'hEE);
    check("rstw_dacq_held", 32'(core_dacq), 32'h0);
    set_core(0, 4'b0001, 8'h20, 8'h00);
    RSTn = 1'b1;
    tick;
    check("rstw_first_grant", 32'(grant_id), 32'h0);
    check("rstw_first_we",    32'(mem_we),   32'h0);
    tick;
    tick;
    check("rstw_dacq", 32'(core_dacq),      32'h1);
    check("rstw_data", 32'(core_ddin[7:0]), 32'hA5);
    set_core(0, 4'b0000, 8'h00, 8'h00);
    set_core(2, 4'b0000, 8'h00, 8'h00);
    tick;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
